// File: rtl/vsram_read_ctrl_pkg.sv
// Shared vSRAM constants and types.
// Used by both the read and write paths.
package vsram_read_ctrl_pkg;

  localparam int VSRAM_NUM_BANKS = 4;
  localparam int VSRAM_ADDR_W    = 9;
  localparam int VSRAM_DATA_W    = 48;
  localparam int VSRAM_CNT_W     = 3;

  localparam logic [VSRAM_ADDR_W-1:0] VSRAM_IDLE_ADDR = 9'h0FF;

  typedef logic [1:0]              vsram_bank_t;
  typedef logic [VSRAM_ADDR_W-1:0] vsram_addr_t;
  typedef logic [VSRAM_DATA_W-1:0] vsram_data_t;
  typedef logic [VSRAM_CNT_W-1:0]  vsram_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } vsram_rd_state_e;

endpackage

// File: rtl/vsram_read_ctrl_if.sv
// Request/response and SRAM bank bus of the vSRAM read path.
// slave = controller side, master = requester and SRAM models.
interface vsram_read_ctrl_if;
  import vsram_read_ctrl_pkg::*;

  logic        in_readReq;
  vsram_bank_t in_vsramNum;
  vsram_addr_t in_colNum;
  logic        readReady;
  logic        readVsramDoneFlag;
  vsram_data_t out_dataReadVal;

  vsram_addr_t sram_1_readAddressline;
  vsram_addr_t sram_2_readAddressline;
  vsram_addr_t sram_3_readAddressline;
  vsram_addr_t sram_4_readAddressline;
  logic        sram_1_readEnable;
  logic        sram_2_readEnable;
  logic        sram_3_readEnable;
  logic        sram_4_readEnable;
  vsram_data_t sram_1_readData;
  vsram_data_t sram_2_readData;
  vsram_data_t sram_3_readData;
  vsram_data_t sram_4_readData;

  modport slave (
    input  in_readReq, in_vsramNum, in_colNum,
    input  sram_1_readData, sram_2_readData,
    input  sram_3_readData, sram_4_readData,
    output readReady, readVsramDoneFlag,
    output out_dataReadVal,
    output sram_1_readAddressline,
    output sram_2_readAddressline,
    output sram_3_readAddressline,
    output sram_4_readAddressline,
    output sram_1_readEnable, sram_2_readEnable,
    output sram_3_readEnable, sram_4_readEnable
  );

  modport master (
    output in_readReq, in_vsramNum, in_colNum,
    output sram_1_readData, sram_2_readData,
    output sram_3_readData, sram_4_readData,
    input  readReady, readVsramDoneFlag,
    input  out_dataReadVal,
    input  sram_1_readAddressline,
    input  sram_2_readAddressline,
    input  sram_3_readAddressline,
    input  sram_4_readAddressline,
    input  sram_1_readEnable, sram_2_readEnable,
    input  sram_3_readEnable, sram_4_readEnable
  );

endinterface

// File: rtl/vsram_bank_decode.sv
// One-hot bank enable and address fan-out.
// Unselected banks park on IDLE_ADDR.
module vsram_bank_decode
  import vsram_read_ctrl_pkg::*;
#(
  parameter vsram_addr_t IDLE_ADDR = VSRAM_IDLE_ADDR
) (
  input  vsram_bank_t                       i_bank,
  input  vsram_addr_t                       i_col,
  input  logic                              i_strobe,
  output logic [VSRAM_NUM_BANKS-1:0]        o_en,
  output vsram_addr_t [VSRAM_NUM_BANKS-1:0] o_addr
);

  always_comb begin
    o_en   = '0;
    o_addr = {VSRAM_NUM_BANKS{IDLE_ADDR}};
    for (int i = 0; i < VSRAM_NUM_BANKS; i++) begin
      if (i_strobe && i_bank == vsram_bank_t'(i)) begin
        o_en[i]   = 1'b1;
        o_addr[i] = i_col;
      end
    end
  end

endmodule

// File: rtl/vsram_read_ctrl.sv
// Single-word read controller for the four-bank vSRAM.
// Issues one strobe, waits the bank latency, returns the word.
module vsram_read_ctrl
  import vsram_read_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_RD_LATENCY = 1,
  parameter vsram_addr_t IDLE_ADDR       = VSRAM_IDLE_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  vsram_read_ctrl_if.slave   bus
);

  localparam vsram_cnt_t LAT_M1 =
    vsram_cnt_t'(SRAM_RD_LATENCY - 1);

  vsram_rd_state_e r_state;
  vsram_rd_state_e w_nxt;
  vsram_bank_t     r_bank;
  vsram_bank_t     w_bank;
  vsram_addr_t     r_col;
  vsram_addr_t     w_col;
  vsram_cnt_t      r_cnt;
  vsram_cnt_t      w_cnt;
  logic            r_ready;
  logic            r_done;
  vsram_data_t     r_data;
  vsram_data_t     w_rdata;
  logic            w_acc;
  logic            w_cap;

  logic [VSRAM_NUM_BANKS-1:0]        r_en;
  logic [VSRAM_NUM_BANKS-1:0]        w_en;
  vsram_addr_t [VSRAM_NUM_BANKS-1:0] r_addr;
  vsram_addr_t [VSRAM_NUM_BANKS-1:0] w_addr;

  assign w_acc = bus.in_readReq & r_ready;

  always_comb begin
    w_nxt  = r_state;
    w_bank = r_bank;
    w_col  = r_col;
    w_cnt  = r_cnt;
    w_cap  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_nxt = ST_IDLE;
        if (w_acc) begin
          w_nxt  = ST_ISSUE;
          w_bank = bus.in_vsramNum;
          w_col  = bus.in_colNum;
        end
      end
      ST_ISSUE: begin
        w_nxt = ST_WAIT;
        w_cnt = LAT_M1;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_nxt = ST_DONE;
          w_cap = 1'b1;
        end else begin
          w_cnt = r_cnt - vsram_cnt_t'(1);
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // Capture mux follows the latched bank only.
  always_comb begin
    w_rdata = bus.sram_1_readData;
    unique case (r_bank)
      2'd0: w_rdata = bus.sram_1_readData;
      2'd1: w_rdata = bus.sram_2_readData;
      2'd2: w_rdata = bus.sram_3_readData;
      2'd3: w_rdata = bus.sram_4_readData;
      default: w_rdata = bus.sram_1_readData;
    endcase
  end

  vsram_bank_decode #(
    .IDLE_ADDR (IDLE_ADDR)
  ) u_dec (
    .i_bank   (w_bank),
    .i_col    (w_col),
    .i_strobe (w_nxt == ST_ISSUE),
    .o_en     (w_en),
    .o_addr   (w_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_bank  <= '0;
      r_col   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_en    <= '0;
      r_addr  <= {VSRAM_NUM_BANKS{IDLE_ADDR}};
    end else begin
      r_state <= w_nxt;
      r_bank  <= w_bank;
      r_col   <= w_col;
      r_cnt   <= w_cnt;
      r_ready <= (w_nxt == ST_IDLE) ||
                 (w_nxt == ST_DONE);
      r_done  <= (w_nxt == ST_DONE);
      r_en    <= w_en;
      r_addr  <= w_addr;
      if (w_cap) r_data <= w_rdata;
    end
  end

  assign bus.readReady         = r_ready;
  assign bus.readVsramDoneFlag = r_done;
  assign bus.out_dataReadVal   = r_data;

  assign bus.sram_1_readEnable = r_en[0];
  assign bus.sram_2_readEnable = r_en[1];
  assign bus.sram_3_readEnable = r_en[2];
  assign bus.sram_4_readEnable = r_en[3];

  assign bus.sram_1_readAddressline = r_addr[0];
  assign bus.sram_2_readAddressline = r_addr[1];
  assign bus.sram_3_readAddressline = r_addr[2];
  assign bus.sram_4_readAddressline = r_addr[3];

endmodule

// File: tb/tb_vsram_read_ctrl.sv
// Bench for vsram_read_ctrl at latencies 1 and 3.
// A transaction timeline model predicts every output each cycle.
module tb_vsram_read_ctrl;
  import vsram_read_ctrl_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [8:0] IA = 9'h0FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  num = '0;
  logic [8:0]  col = '0;
  logic [47:0] bd [4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat [2] = '{LAT_A, LAT_B};

  always #5 clk = ~clk;

  vsram_read_ctrl_if if_a();
  vsram_read_ctrl_if if_b();

  vsram_read_ctrl #(.SRAM_RD_LATENCY(LAT_A)) u_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a)
  );

  vsram_read_ctrl #(.SRAM_RD_LATENCY(LAT_B)) u_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b)
  );

  assign if_a.in_readReq      = req;
  assign if_a.in_vsramNum     = num;
  assign if_a.in_colNum       = col;
  assign if_a.sram_1_readData = bd[0];
  assign if_a.sram_2_readData = bd[1];
  assign if_a.sram_3_readData = bd[2];
  assign if_a.sram_4_readData = bd[3];
  assign if_b.in_readReq      = req;
  assign if_b.in_vsramNum     = num;
  assign if_b.in_colNum       = col;
  assign if_b.sram_1_readData = bd[0];
  assign if_b.sram_2_readData = bd[1];
  assign if_b.sram_3_readData = bd[2];
  assign if_b.sram_4_readData = bd[3];

  logic        d_ready [2];
  logic        d_done  [2];
  logic [47:0] d_data  [2];
  logic [3:0]  d_en    [2];
  logic [35:0] d_addr  [2];

  assign d_ready[0] = if_a.readReady;
  assign d_done[0]  = if_a.readVsramDoneFlag;
  assign d_data[0]  = if_a.out_dataReadVal;
  assign d_en[0]    = {if_a.sram_4_readEnable,
                       if_a.sram_3_readEnable,
                       if_a.sram_2_readEnable,
                       if_a.sram_1_readEnable};
  assign d_addr[0]  = {if_a.sram_4_readAddressline,
                       if_a.sram_3_readAddressline,
                       if_a.sram_2_readAddressline,
                       if_a.sram_1_readAddressline};
  assign d_ready[1] = if_b.readReady;
  assign d_done[1]  = if_b.readVsramDoneFlag;
  assign d_data[1]  = if_b.out_dataReadVal;
  assign d_en[1]    = {if_b.sram_4_readEnable,
                       if_b.sram_3_readEnable,
                       if_b.sram_2_readEnable,
                       if_b.sram_1_readEnable};
  assign d_addr[1]  = {if_b.sram_4_readAddressline,
                       if_b.sram_3_readAddressline,
                       if_b.sram_2_readAddressline,
                       if_b.sram_1_readAddressline};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h",
               tag, $time, obs, exp);
    end
  endtask

  // Model: a read accepted at edge t0 strobes after t0,
  // captures at edge t0+1+lat and pulses done after it.
  bit          m_inf  [2] = '{0, 0};
  int          m_t0   [2] = '{0, 0};
  logic [1:0]  m_bank [2];
  logic        e_ready[2] = '{1'b0, 1'b0};
  logic        e_done [2] = '{1'b0, 1'b0};
  logic [47:0] e_data [2] = '{48'h0, 48'h0};
  logic [3:0]  e_en   [2] = '{4'h0, 4'h0};
  logic [35:0] e_addr [2] = '{{4{IA}}, {4{IA}}};

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      e_done[k] = 1'b0;
      e_en[k]   = 4'h0;
      e_addr[k] = {4{IA}};
      if (rst) begin
        m_inf[k]   = 0;
        e_ready[k] = 1'b0;
        e_data[k]  = '0;
      end else if (m_inf[k] &&
                   cyc == m_t0[k] + 1 + lat[k]) begin
        e_data[k]  = bd[m_bank[k]];
        e_done[k]  = 1'b1;
        e_ready[k] = 1'b1;
        m_inf[k]   = 0;
      end else if (m_inf[k]) begin
        e_ready[k] = 1'b0;
      end else if (e_ready[k] && req) begin
        m_inf[k]  = 1;
        m_t0[k]   = cyc;
        m_bank[k] = num;
        e_en[k][num]          = 1'b1;
        e_addr[k][9*num +: 9] = col;
        e_ready[k] = 1'b0;
      end else begin
        e_ready[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), 64'(d_ready[k]),
          64'(e_ready[k]));
      chk($sformatf("done%0d", k), 64'(d_done[k]),
          64'(e_done[k]));
      chk($sformatf("data%0d", k), 64'(d_data[k]),
          64'(e_data[k]));
      chk($sformatf("en%0d", k), 64'(d_en[k]),
          64'(e_en[k]));
      chk($sformatf("addr%0d", k), 64'(d_addr[k]),
          64'(e_addr[k]));
    end
  end

  function automatic logic [47:0] rnd48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[47:0];
  endfunction

  // Waits the accept edge, then measures cycles to done.
  // Non-selected banks 0,1,3 churn meanwhile.
  task automatic lat_probe(output int l0, output int l1);
    l0 = -1;
    l1 = -1;
    @(posedge clk);
    #2 req = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (d_done[0] && l0 < 0) l0 = n;
      if (d_done[1] && l1 < 0) l1 = n;
      bd[0] = rnd48();
      bd[1] = rnd48();
      bd[3] = rnd48();
    end
  endtask

  initial begin
    int l0;
    int l1;
    for (int i = 0; i < 4; i++) bd[i] = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    bd[2] = 48'hABCD_1234_5678;
    req = 1'b1;
    num = 2'd2;
    col = 9'h1A3;
    lat_probe(l0, l1);
    chk("lat_a", 64'(l0), 64'(LAT_A + 1));
    chk("lat_b", 64'(l1), 64'(LAT_B + 1));
    chk("word_a", 64'(d_data[0]), 64'h0000_ABCD_1234_5678);
    chk("word_b", 64'(d_data[1]), 64'h0000_ABCD_1234_5678);

    @(posedge clk);
    #2;
    bd[0] = 48'h0000_5555_AAAA;
    bd[3] = 48'hFEED_FACE_0123;
    req = 1'b1;
    num = 2'd0;
    col = 9'd5;
    @(posedge clk);
    #2;
    num = 2'd3;
    col = 9'h100;
    repeat (8) @(posedge clk);
    #2 req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_a", 64'(d_data[0]), 64'h0000_FEED_FACE_0123);
    chk("b2b_b", 64'(d_data[1]), 64'h0000_FEED_FACE_0123);

    #1;
    req = 1'b1;
    num = 2'd1;
    col = 9'h0FF;
    @(posedge clk);
    #2;
    num = 2'd0;
    col = 9'h042;
    @(posedge clk);
    #2 req = 1'b0;
    repeat (8) @(posedge clk);

    #2;
    req = 1'b1;
    num = 2'd3;
    col = 9'h033;
    @(posedge clk);
    #2 req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    bd[2] = 48'h0123_4567_89AB;
    req = 1'b1;
    num = 2'd2;
    col = 9'h011;
    lat_probe(l0, l1);
    chk("rst_lat_a", 64'(l0), 64'(LAT_A + 1));
    chk("rst_lat_b", 64'(l1), 64'(LAT_B + 1));
    chk("rst_word", 64'(d_data[1]), 64'h0000_0123_4567_89AB);

    repeat (3000) begin
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 2) == 0);
      num = 2'($urandom());
      col = ($urandom_range(0, 7) == 0) ? IA
                                        : 9'($urandom());
      for (int i = 0; i < 4; i++) bd[i] = rnd48();
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 1'b0;
    repeat (10) @(posedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
